board_link_ctrl: RTL and testbench

- Sequences the 162-bit UART board receiver (9x9 board, 81 cells x 2 bits). It frames each packet from the receiver's ready signal, validates cell encodings and debounces across consecutive packets.
- Emits each changed, stable board to the game-logic consumer over a valid/ready handshake.
- Watches the link and resets the receiver on timeout or on a stuck packet.

---
 rtl/board_pkg.sv | 20 ++
 rtl/board_validator.sv | 16 +
 rtl/board_link_ctrl.sv | 167 ++++++++++++++++
 tb/tb_board_link_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared constants and types for the board link: packet geometry, cell
// encodings and the link controller state encoding.
package board_pkg;

    localparam int PKT_BITS  = 162;
    localparam int NUM_CELLS = 81;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;
    localparam logic [1:0] CELL_BAD   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_CHECK,
        S_RECOVER
    } state_t;

endpackage

// File: rtl/board_validator.sv
// Flags a board that contains at least one cell with the illegal 2'b11 encoding.
module board_validator
    import board_pkg::*;
(
    input  logic [PKT_BITS-1:0] board,
    output logic                illegal
);

    always_comb begin
        illegal = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            illegal = illegal | (board[2*i+1] & board[2*i]);
        end
    end

endmodule

// File: rtl/board_link_ctrl.sv
// Frames receiver packets, debounces valid boards across consecutive packets,
// hands committed boards to the consumer and recovers a stalled receiver link.
module board_link_ctrl
    import board_pkg::*;
#(
    parameter int STABLE_CNT  = 3,
    parameter int TIMEOUT_CYC = 65_000_000,
    parameter int MAX_PKT_CYC = 1_200_000
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rx_ready,
    input  logic [PKT_BITS-1:0] rx_data,
    output logic                rx_rst_out,
    output logic [PKT_BITS-1:0] board_out,
    output logic                board_valid,
    input  logic                board_ready,
    output logic                link_lost,
    output logic [15:0]         pkt_count,
    output logic [15:0]         drop_count
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam int PKT_W  = $clog2(MAX_PKT_CYC + 1);
    localparam int RUN_W  = $clog2(STABLE_CNT + 1);

    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [PKT_W-1:0]  PKT_LAST   = PKT_W'(MAX_PKT_CYC - 1);
    localparam logic [RUN_W-1:0]  RUN_STABLE = RUN_W'(STABLE_CNT);

    state_t              state, state_nxt;
    logic                rx_ready_q;
    logic [PKT_BITS-1:0] cap_reg, cand_reg, shadow_reg, emitted_reg;
    logic [RUN_W-1:0]    run_cnt, run_nxt;
    logic [IDLE_W-1:0]   idle_timer;
    logic [PKT_W-1:0]    pkt_timer;
    logic                commit_q;
    logic                cap_illegal, cap_same, commit_now;
    logic                rx_fall, rx_rise;
    logic                do_capture, do_check, do_stuck, do_timeout;

    assign rx_fall = rx_ready_q & ~rx_ready;
    assign rx_rise = rx_ready & ~rx_ready_q;

    board_validator u_validator (
        .board   (cap_reg),
        .illegal (cap_illegal)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= S_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        do_capture = 1'b0;
        do_check   = 1'b0;
        do_stuck   = 1'b0;
        do_timeout = 1'b0;
        rx_rst_out = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_fall) begin
                    state_nxt = S_RECV;
                end else if (idle_timer == IDLE_LAST) begin
                    do_timeout = 1'b1;
                    state_nxt  = S_RECOVER;
                end
            end
            S_RECV: begin
                if (rx_rise) begin
                    do_capture = 1'b1;
                    state_nxt  = S_CHECK;
                end else if (pkt_timer == PKT_LAST) begin
                    do_stuck  = 1'b1;
                    state_nxt = S_RECOVER;
                end
            end
            S_CHECK: begin
                do_check  = 1'b1;
                state_nxt = S_IDLE;
            end
            S_RECOVER: begin
                rx_rst_out = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A commit is the step into STABLE_CNT, either by extending a run or by
    // starting a new one when STABLE_CNT is 1.
    assign cap_same = (cap_reg == cand_reg);

    always_comb begin
        run_nxt = run_cnt;
        if (cap_illegal)                run_nxt = '0;
        else if (!cap_same)             run_nxt = RUN_W'(1);
        else if (run_cnt != RUN_STABLE) run_nxt = run_cnt + RUN_W'(1);
    end

    assign commit_now = do_check & ~cap_illegal & (run_nxt == RUN_STABLE) &
                        (~cap_same | (run_cnt != RUN_STABLE));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_ready_q  <= 1'b1;
            cap_reg     <= '0;
            cand_reg    <= '0;
            shadow_reg  <= '0;
            emitted_reg <= '0;
            run_cnt     <= '0;
            idle_timer  <= '0;
            pkt_timer   <= '0;
            commit_q    <= 1'b0;
            link_lost   <= 1'b0;
            pkt_count   <= '0;
            drop_count  <= '0;
            board_out   <= '0;
            board_valid <= 1'b0;
        end else begin
            rx_ready_q <= rx_ready;
            commit_q   <= commit_now;

            if (state == S_RECV) pkt_timer <= pkt_timer + PKT_W'(1);
            else                 pkt_timer <= '0;

            if (do_capture || state == S_RECOVER) idle_timer <= '0;
            else                                  idle_timer <= idle_timer + IDLE_W'(1);

            if (do_capture) begin
                cap_reg <= rx_data;
                if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
            end

            if (do_timeout) link_lost <= 1'b1;

            if (do_stuck) begin
                run_cnt <= '0;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end

            if (do_check) begin
                run_cnt <= run_nxt;
                if (cap_illegal) begin
                    if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                end else begin
                    link_lost <= 1'b0;
                    if (!cap_same) cand_reg <= cap_reg;
                end
            end

            if (commit_q) shadow_reg <= cand_reg;

            // Output slot: board_out is frozen until the consumer takes it.
            if (board_valid) begin
                if (board_ready) board_valid <= 1'b0;
            end else if (shadow_reg != emitted_reg) begin
                board_out   <= shadow_reg;
                emitted_reg <= shadow_reg;
                board_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_board_link_ctrl.sv
// Scenario bench for board_link_ctrl: debounce, illegal cells, backpressure,
// link timeout and stuck-packet recovery.
module tb_board_link_ctrl;

    localparam int W      = 162;
    localparam int STABLE = 3;

    logic         clk_in;
    logic         rst_n_in;
    logic         rx_ready;
    logic [W-1:0] rx_data;
    logic         rx_rst_out;
    logic [W-1:0] board_out;
    logic         board_valid;
    logic         board_ready;
    logic         link_lost;
    logic [15:0]  pkt_count;
    logic [15:0]  drop_count;

    board_link_ctrl #(
        .STABLE_CNT  (STABLE),
        .TIMEOUT_CYC (1000),
        .MAX_PKT_CYC (200)
    ) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_rst_out  (rx_rst_out),
        .board_out   (board_out),
        .board_valid (board_valid),
        .board_ready (board_ready),
        .link_lost   (link_lost),
        .pkt_count   (pkt_count),
        .drop_count  (drop_count)
    );

    // Clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard and reference model state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_cand;
    logic [W-1:0] m_emitted;
    int           m_run;
    int           m_pkt;
    int           m_drop;

    logic [W-1:0] brd_a;
    logic [W-1:0] brd_b;
    logic [W-1:0] brd_c;
    logic [W-1:0] brd_bad;

    always @(negedge clk_in) begin
        if (rst_n_in && board_valid && board_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL handshake_unexpected: got board %h, expected no board", board_out);
            end else begin
                logic [W-1:0] exp_b;
                exp_b = exp_q.pop_front();
                if (board_out !== exp_b) begin
                    n_err++;
                    $display("FAIL handshake_board: got %h, expected %h", board_out, exp_b);
                end
            end
        end
    end

    function automatic bit has_bad_cell(input logic [W-1:0] b);
        for (int i = 0; i < 81; i++) begin
            if (b[2*i+1] && b[2*i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_pkt(input logic [W-1:0] b);
        bit commit;
        commit = 1'b0;
        m_pkt++;
        if (has_bad_cell(b)) begin
            m_drop++;
            m_run = 0;
        end else if (b == m_cand) begin
            if (m_run < STABLE) begin
                m_run++;
                commit = (m_run == STABLE);
            end
        end else begin
            m_cand = b;
            m_run  = 1;
            commit = (STABLE == 1);
        end
        if (commit && b != m_emitted) begin
            exp_q.push_back(b);
            m_emitted = b;
        end
    endtask

    task automatic apply_reset();
        rst_n_in    = 1'b0;
        rx_ready    = 1'b1;
        rx_data     = '0;
        board_ready = 1'b1;
        exp_q.delete();
        m_cand    = '0;
        m_emitted = '0;
        m_run     = 0;
        m_pkt     = 0;
        m_drop    = 0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    // Driver: shift-in phase with rx_ready low, then rise and watch for the
    // first board_valid; lat counts cycles from the edge that sees the rise.
    task automatic send_pkt(input logic [W-1:0] b, output int lat);
        @(posedge clk_in); #1;
        rx_ready = 1'b0;
        rx_data  = b;
        repeat ($urandom_range(3, 10)) @(posedge clk_in);
        #1;
        model_pkt(b);
        rx_ready = 1'b1;
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (board_valid && lat < 0) lat = i - 1;
        end
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drained: %0d boards still expected, expected 0", name, exp_q.size());
        end
    endtask

    task automatic check_lat(input string name, input int got, input int exp_lat);
        n_cmp++;
        if (got != exp_lat) begin
            n_err++;
            $display("FAIL %s_latency: got %0d, expected %0d", name, got, exp_lat);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk_in);
        n_cmp++;
        if (board_out !== '0 || board_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_board: valid=%b out=%h, expected 0/0", board_valid, board_out);
        end
        n_cmp++;
        if (rx_rst_out !== 1'b0 || link_lost !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: rx_rst=%b link_lost=%b, expected 0/0", rx_rst_out, link_lost);
        end
        n_cmp++;
        if (pkt_count !== 16'd0 || drop_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_counts: pkt=%0d drop=%0d, expected 0/0", pkt_count, drop_count);
        end
    endtask

    task automatic test_stable();
        int lat;
        apply_reset();
        send_pkt(brd_a, lat); check_lat("stable_p1", lat, -1);
        send_pkt(brd_a, lat); check_lat("stable_p2", lat, -1);
        send_pkt(brd_a, lat); check_lat("stable_p3", lat, 3);
        send_pkt(brd_a, lat); check_lat("stable_p4", lat, -1);
        n_cmp++;
        if (pkt_count !== 16'(m_pkt)) begin
            n_err++;
            $display("FAIL stable_pkt_count: got %0d, expected %0d", pkt_count, m_pkt);
        end
        check_drained("stable");
    endtask

    task automatic test_run_reset();
        int lat;
        apply_reset();
        send_pkt(brd_a, lat);
        send_pkt(brd_a, lat);
        send_pkt(brd_b, lat); check_lat("run_reset_b1", lat, -1);
        send_pkt(brd_b, lat); check_lat("run_reset_b2", lat, -1);
        send_pkt(brd_b, lat); check_lat("run_reset_b3", lat, 3);
        check_drained("run_reset");
    endtask

    task automatic test_illegal();
        int lat;
        apply_reset();
        send_pkt(brd_a, lat);
        send_pkt(brd_a, lat);
        send_pkt(brd_bad, lat);
        n_cmp++;
        if (drop_count !== 16'(m_drop)) begin
            n_err++;
            $display("FAIL illegal_drop_count: got %0d, expected %0d", drop_count, m_drop);
        end
        send_pkt(brd_a, lat);
        send_pkt(brd_a, lat); check_lat("illegal_a2", lat, -1);
        send_pkt(brd_a, lat); check_lat("illegal_a3", lat, 3);
        check_drained("illegal");
    endtask

    task automatic test_backpressure();
        int lat;
        apply_reset();
        board_ready = 1'b0;
        repeat (3) send_pkt(brd_a, lat);
        repeat (3) send_pkt(brd_c, lat);
        n_cmp++;
        if (board_valid !== 1'b1 || board_out !== brd_a) begin
            n_err++;
            $display("FAIL backpressure_hold: valid=%b out=%h, expected 1/%h", board_valid, board_out, brd_a);
        end
        @(posedge clk_in); #1;
        board_ready = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        n_cmp++;
        if (board_valid !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_gap: valid=%b, expected 0", board_valid);
        end
        @(negedge clk_in);
        n_cmp++;
        if (board_valid !== 1'b1 || board_out !== brd_c) begin
            n_err++;
            $display("FAIL backpressure_reissue: valid=%b out=%h, expected 1/%h", board_valid, board_out, brd_c);
        end
        @(negedge clk_in);
        check_drained("backpressure");
    endtask

    task automatic test_timeout();
        int t1, t2, lat;
        apply_reset();
        t1 = -1;
        t2 = -1;
        for (int i = 0; i < 2400 && t2 < 0; i++) begin
            @(negedge clk_in);
            if (rx_rst_out) begin
                if (t1 < 0) t1 = i;
                else        t2 = i;
            end
        end
        n_cmp++;
        if (t1 < 0 || t2 < 0) begin
            n_err++;
            $display("FAIL timeout_pulse: pulses at %0d/%0d, expected two pulses", t1, t2);
        end else if (t2 - t1 != 1001) begin
            n_err++;
            $display("FAIL timeout_period: got %0d, expected 1001", t2 - t1);
        end
        @(negedge clk_in);
        n_cmp++;
        if (rx_rst_out !== 1'b0 || link_lost !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_flags: rx_rst=%b link_lost=%b, expected 0/1", rx_rst_out, link_lost);
        end
        send_pkt(brd_a, lat);
        n_cmp++;
        if (link_lost !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_clear: link_lost=%b, expected 0", link_lost);
        end
    endtask

    task automatic test_stuck();
        int t;
        apply_reset();
        @(posedge clk_in); #1;
        rx_ready = 1'b0;
        rx_data  = brd_a;
        t = -1;
        for (int i = 1; i <= 260 && t < 0; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (rx_rst_out) t = i - 1;
        end
        m_drop++;
        m_run = 0;
        n_cmp++;
        if (t != 200) begin
            n_err++;
            $display("FAIL stuck_pulse: got %0d cycles, expected 200", t);
        end
        n_cmp++;
        if (drop_count !== 16'(m_drop)) begin
            n_err++;
            $display("FAIL stuck_drop_count: got %0d, expected %0d", drop_count, m_drop);
        end
        // Start a fresh packet, then pull reset in the middle of it.
        @(posedge clk_in); #1;
        rx_ready = 1'b1;
        @(posedge clk_in); #1;
        rx_ready = 1'b0;
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        n_cmp++;
        if (drop_count !== 16'd0 || pkt_count !== 16'd0 || link_lost !== 1'b0 ||
            rx_rst_out !== 1'b0 || board_valid !== 1'b0 || board_out !== '0) begin
            n_err++;
            $display("FAIL async_reset: drop=%0d pkt=%0d lost=%b rst=%b valid=%b, expected all 0",
                     drop_count, pkt_count, link_lost, rx_rst_out, board_valid);
        end
        apply_reset();
    endtask

    initial begin
        brd_a   = '0; brd_a[0]   = 1'b1;
        brd_b   = '0; brd_b[1]   = 1'b1;
        brd_c   = '0; brd_c[2]   = 1'b1;
        brd_bad = brd_a;
        brd_bad[81:80] = 2'b11;

        test_reset();
        test_stable();
        test_run_reset();
        test_illegal();
        test_backpressure();
        test_timeout();
        test_stuck();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
